inout_sram_loader: RTL and testbench

//  Write-side front end for the 64-lane banked input/output SRAM array.

---
 rtl/inout_sram_loader.sv | 102 ++++++++++
 tb/tb_inout_sram_loader.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/inout_sram_loader.sv
// rtl/inout_sram_loader.sv - lane-major stream-to-banked-SRAM write front end
// Optional feature: LOADER_ABORT_EN adds the abort input.
module inout_sram_loader #(
  parameter int NUM_BANKS   = 64,
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int TOTAL_WORDS = 784
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
`ifdef LOADER_ABORT_EN
  input  logic                  abort,
`endif
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [NUM_BANKS-1:0]  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  output logic                  busy,
  output logic                  done
);

  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int WORD_W = (TOTAL_WORDS > 1) ? $clog2(TOTAL_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t            state, nextState;
  logic [BANK_W-1:0] bankCnt;
  logic [ADDR_WIDTH-1:0] rowCnt;
  logic [WORD_W-1:0] wordCnt;
  logic              accept;
  logic              lastWord;
  logic              abortHit;

`ifdef LOADER_ABORT_EN
  assign abortHit = abort & (state != IDLE);
`else
  assign abortHit = 1'b0;
`endif

  assign accept   = in_valid & in_ready;
  assign lastWord = (wordCnt == WORD_W'(TOTAL_WORDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start) nextState = LOAD;
      LOAD:    if (accept && lastWord) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
    // Abort wins over a final accept landing on the same edge.
    if (abortHit) nextState = IDLE;
  end

  always_comb begin
    in_ready = (state == LOAD);
    busy     = (state != IDLE);
    done     = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_we    <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      bankCnt    <= '0;
      rowCnt     <= '0;
      wordCnt    <= '0;
    end else begin
      sram_we <= '0;
      if (abortHit || (state == IDLE && start)) begin
        bankCnt <= '0;
        rowCnt  <= '0;
        wordCnt <= '0;
      end else if (accept) begin
        sram_we    <= {{(NUM_BANKS-1){1'b0}}, 1'b1} << bankCnt;
        sram_addr  <= rowCnt;
        sram_wdata <= in_data;
        wordCnt    <= wordCnt + 1'b1;
        if (bankCnt == BANK_W'(NUM_BANKS - 1)) begin
          bankCnt <= '0;
          rowCnt  <= rowCnt + 1'b1;
        end else begin
          bankCnt <= bankCnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_inout_sram_loader.sv
// tb/tb_inout_sram_loader.sv - scoreboard bench for inout_sram_loader
module tb_inout_sram_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [63:0] sram_we;
  logic [3:0]  sram_addr;
  logic [15:0] sram_wdata;
  logic        busy;
  logic        done;
`ifdef LOADER_ABORT_EN
  logic        abort;
`endif

  always #5 clk = ~clk;

  inout_sram_loader dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
`ifdef LOADER_ABORT_EN
    .abort(abort),
`endif
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .sram_we(sram_we),
    .sram_addr(sram_addr),
    .sram_wdata(sram_wdata),
    .busy(busy),
    .done(done)
  );

  typedef struct packed {
    logic [5:0]  bank;
    logic [3:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t         expQ[$];
  int          checks = 0;
  int          errors = 0;
  int          writeCount = 0;
  int          doneCount = 0;
  bit          monEn = 1'b0;
  logic [15:0] mem [64][13];
  int          mb;
  wr_t         me;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (monEn && rst_n) begin
      chk("we_onehot0", 64'($onehot0(sram_we)), 64'd1);
      if (sram_we != '0) begin
        mb = 0;
        for (int i = 0; i < 64; i++) if (sram_we[i]) mb = i;
        writeCount++;
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got bank %0d addr %0d expected no write", mb, sram_addr);
        end else begin
          me = expQ.pop_front();
          chk("wr_bank", 64'(mb), 64'(me.bank));
          chk("wr_addr", 64'(sram_addr), 64'(me.addr));
          chk("wr_data", 64'(sram_wdata), 64'(me.data));
          if (sram_addr < 4'd13) mem[mb][sram_addr] = sram_wdata;
        end
      end
      if (done) begin
        doneCount++;
        chk("done_we", sram_we, 64'd1 << 15);
        chk("done_addr", 64'(sram_addr), 64'd12);
        chk("done_q_empty", 64'(expQ.size()), 64'd0);
      end
    end
  end

  task automatic doStart();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input int maxWords, input bit gaps, input bit pulseStart);
    int k = 0;
    int cyc = 0;
    while (k < maxWords && cyc < 5000) begin
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = in_valid ? 16'(k) : 16'($urandom);
      start    = pulseStart && (k == 200);
      @(negedge clk);
      if (in_valid && in_ready) begin
        expQ.push_back('{bank: 6'(k % 64), addr: 4'(k / 64), data: 16'(k)});
        k++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (k < maxWords) chk("feed_timeout", 64'(k), 64'(maxWords));
    in_valid = 1'b0;
    start    = 1'b0;
    if (pulseStart) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic fullLoad(input bit gaps, input bit pulseStart);
    int w0 = writeCount;
    int d0 = doneCount;
    for (int b = 0; b < 64; b++)
      for (int a = 0; a < 13; a++) mem[b][a] = 16'hDEAD;
    doStart();
    feed(784, gaps, pulseStart);
    repeat (3) @(posedge clk);
    #1;
    chk("load_writes", 64'(writeCount - w0), 64'd784);
    chk("load_dones", 64'(doneCount - d0), 64'd1);
    chk("post_in_ready", 64'(in_ready), 64'd0);
    chk("post_busy", 64'(busy), 64'd0);
    chk("post_q_empty", 64'(expQ.size()), 64'd0);
    chk("mem_b0_a0", 64'(mem[0][0]), 64'd0);
    chk("mem_b63_a0", 64'(mem[63][0]), 64'd63);
    chk("mem_b0_a1", 64'(mem[0][1]), 64'd64);
    chk("mem_b5_a7", 64'(mem[5][7]), 64'd453);
    chk("mem_b63_a11", 64'(mem[63][11]), 64'd767);
    chk("mem_b15_a12", 64'(mem[15][12]), 64'd783);
    chk("mem_b16_a12", 64'(mem[16][12]), 64'hDEAD);
  endtask

  task automatic checkIdleOutputs(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_we"}, sram_we, 64'd0);
    chk({tag, "_addr"}, 64'(sram_addr), 64'd0);
    chk({tag, "_wdata"}, 64'(sram_wdata), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    int w0;
    int d0;
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
`ifdef LOADER_ABORT_EN
    abort    = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    checkIdleOutputs("reset");
    rst_n = 1'b1;
    monEn = 1'b1;
    @(posedge clk); #1;

    fullLoad(1'b0, 1'b0);
    fullLoad(1'b1, 1'b0);
    fullLoad(1'b0, 1'b1);

    // Reset mid-load after 300 accepts, then a clean reload.
    doStart();
    feed(300, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkIdleOutputs("midreset");
    chk("midreset_q_empty", 64'(expQ.size()), 64'd0);
    expQ.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    fullLoad(1'b0, 1'b0);

`ifdef LOADER_ABORT_EN
    w0 = writeCount;
    d0 = doneCount;
    doStart();
    feed(500, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = 16'hBEEF;
    abort    = 1'b1;
    @(posedge clk); #1;
    abort    = 1'b0;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_writes", 64'(writeCount - w0), 64'd500);
    chk("abort_no_done", 64'(doneCount - d0), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd0);
    fullLoad(1'b0, 1'b0);
`else
    w0 = 0;
    d0 = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
